// File: rtl/shift_reg_pkg.sv
// Shared mode encodings and sizing helper for the universal shift register family.
package shift_reg_pkg;

    localparam logic [2:0] MODE_HOLD = 3'd0;
    localparam logic [2:0] MODE_LOAD = 3'd1;
    localparam logic [2:0] MODE_SHL  = 3'd2;
    localparam logic [2:0] MODE_SHR  = 3'd3;
    localparam logic [2:0] MODE_ROTL = 3'd4;
    localparam logic [2:0] MODE_ROTR = 3'd5;

    // Bits needed to hold 0..width inclusive.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at MAX once reached.
// Latency 1 cycle from clr/inc to cnt; no backpressure, inc beyond MAX is absorbed.
module sat_counter #(
    parameter int CW  = 4,
    parameter int MAX = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] cnt,
    output logic          at_max
);

    localparam logic [CW-1:0] MAX_V = CW'(MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != MAX_V)) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign at_max = (cnt == MAX_V);

endmodule

// File: rtl/shift_reg_univ.sv
// Universal shift register: hold/load/shift/rotate with a drain counter for serializers.
// Latency 1 cycle to q/cnt; serial outs and drained follow combinationally; en=0 stalls everything.
module shift_reg_univ
    import shift_reg_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            en,
    input  logic [2:0]                      mode,
    input  logic [WIDTH-1:0]                d,
    input  logic                            sin_r,
    input  logic                            sin_l,
    output logic [WIDTH-1:0]                q,
    output logic                            sout_l,
    output logic                            sout_r,
    output logic [cnt_width(WIDTH)-1:0]     cnt,
    output logic                            drained
);

    localparam int CW = cnt_width(WIDTH);

    logic is_load;
    logic is_shift;

    assign is_load  = en && (mode == MODE_LOAD);
    assign is_shift = en && (mode >= MODE_SHL) && (mode <= MODE_ROTR);

    // Reserved modes 6/7 fall into default and behave as HOLD.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RESET_VAL;
        end else if (en) begin
            case (mode)
                MODE_LOAD: q <= d;
                MODE_SHL:  q <= {q[WIDTH-2:0], sin_r};
                MODE_SHR:  q <= {sin_l, q[WIDTH-1:1]};
                MODE_ROTL: q <= {q[WIDTH-2:0], q[WIDTH-1]};
                MODE_ROTR: q <= {q[0], q[WIDTH-1:1]};
                default:   q <= q;
            endcase
        end
    end

    sat_counter #(
        .CW  (CW),
        .MAX (WIDTH)
    ) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (is_load),
        .inc    (is_shift),
        .cnt    (cnt),
        .at_max (drained)
    );

    assign sout_l = q[WIDTH-1];
    assign sout_r = q[0];

endmodule
